// File: rtl/yapp_pkt_tx.sv
// YAPP packet transmitter: buffers a payload, then emits header,
// payload and parity as one contiguous valid burst to the router.
module yapp_pkt_tx #(
  parameter int GAP_CYCLES = 1,
  parameter int CNT_W      = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_addr,
  input  logic [5:0]       cmd_len,
  input  logic             cmd_bad_parity,
  input  logic [7:0]       pl_data,
  input  logic             pl_valid,
  output logic             pl_ready,
  output logic [7:0]       in_data,
  output logic             in_data_vld,
  input  logic             in_suspend,
  output logic             pkt_done,
  output logic             len_err,
  output logic             busy,
  output logic [CNT_W-1:0] pkt_count
);

  typedef enum logic [2:0] {
    IDLE, LOAD, HEADER, PAYLOAD, PARITY, GAP
  } state_t;

  localparam int GLAST = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;
  localparam int GW    = (GLAST > 0) ? $clog2(GLAST + 1) : 1;

  state_t           state_q, state_d;
  logic [1:0]       addr_q, addr_d;
  logic [5:0]       len_q, len_d;
  logic             bad_q, bad_d;
  logic [5:0]       idx_q, idx_d;
  logic [5:0]       nidx;
  logic [7:0]       par_q, par_d;
  logic [7:0]       data_q, data_d;
  logic             vld_q, vld_d;
  logic             done_q, done_d;
  logic             lerr_q, lerr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [GW-1:0]    gcnt_q, gcnt_d;
  logic             xfer;
  logic [7:0]       mem [0:62];

  assign nidx = idx_q + 6'd1;
  assign xfer = vld_q && !in_suspend;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    len_d   = len_q;
    bad_d   = bad_q;
    idx_d   = idx_q;
    par_d   = par_q;
    data_d  = data_q;
    vld_d   = vld_q;
    done_d  = 1'b0;
    lerr_d  = 1'b0;
    cnt_d   = cnt_q;
    gcnt_d  = gcnt_q;
    unique case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          addr_d = cmd_addr;
          len_d  = cmd_len;
          bad_d  = cmd_bad_parity;
          idx_d  = 6'd0;
          par_d  = {cmd_len, cmd_addr};
          if (cmd_len == 6'd0) lerr_d = 1'b1;
          else state_d = LOAD;
        end
      end
      LOAD: begin
        if (pl_valid) begin
          par_d = par_q ^ pl_data;
          idx_d = nidx;
          if (idx_q == len_q - 6'd1) begin
            state_d = HEADER;
            data_d  = {len_q, addr_q};
            vld_d   = 1'b1;
          end
        end
      end
      HEADER: begin
        if (xfer) begin
          state_d = PAYLOAD;
          idx_d   = 6'd0;
          data_d  = mem[0];
        end
      end
      PAYLOAD: begin
        if (xfer) begin
          if (idx_q == len_q - 6'd1) begin
            state_d = PARITY;
            data_d  = par_q ^ {7'b0, bad_q};
          end else begin
            idx_d  = nidx;
            data_d = mem[nidx];
          end
        end
      end
      PARITY: begin
        if (xfer) begin
          data_d  = 8'd0;
          vld_d   = 1'b0;
          done_d  = 1'b1;
          cnt_d   = cnt_q + CNT_W'(1);
          gcnt_d  = '0;
          state_d = (GAP_CYCLES > 0) ? GAP : IDLE;
        end
      end
      GAP: begin
        if (gcnt_q == GW'(GLAST)) state_d = IDLE;
        else gcnt_d = gcnt_q + GW'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      len_q   <= '0;
      bad_q   <= 1'b0;
      idx_q   <= '0;
      par_q   <= '0;
      data_q  <= '0;
      vld_q   <= 1'b0;
      done_q  <= 1'b0;
      lerr_q  <= 1'b0;
      cnt_q   <= '0;
      gcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      bad_q   <= bad_d;
      idx_q   <= idx_d;
      par_q   <= par_d;
      data_q  <= data_d;
      vld_q   <= vld_d;
      done_q  <= done_d;
      lerr_q  <= lerr_d;
      cnt_q   <= cnt_d;
      gcnt_q  <= gcnt_d;
    end
  end

  // Payload storage needs no reset; stale bytes are never read
  always_ff @(posedge clock) begin
    if (state_q == LOAD && pl_valid) mem[idx_q] <= pl_data;
  end

  assign cmd_ready   = (state_q == IDLE);
  assign pl_ready    = (state_q == LOAD);
  assign busy        = (state_q != IDLE);
  assign in_data     = data_q;
  assign in_data_vld = vld_q;
  assign pkt_done    = done_q;
  assign len_err     = lerr_q;
  assign pkt_count   = cnt_q;

endmodule
